// File: rtl/infifo_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : infifo_dispatcher
//  Brief    : Round-robin steering of small-FIFO packets into per-thread
//             input FIFOs, with per-thread FREE/FILLING/BUSY tracking.
//  Revision : 1.0  initial release
// ============================================================================
module infifo_dispatcher #(
    parameter int NUM_THREADS = 8,
    parameter int SEL_W       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   firstword_in,
    input  logic                   lastword_in,
    input  logic                   fifowrite_in,
    input  logic [NUM_THREADS-1:0] thread_done,
    output logic [NUM_THREADS-1:0] firstword_out,
    output logic [NUM_THREADS-1:0] fifowrite_out,
    output logic [NUM_THREADS-1:0] enable_cpu_out,
    output logic                   stop_smallfifo_read,
    output logic [SEL_W-1:0]       cur_thread,
    output logic                   tgt_valid,
    output logic [NUM_THREADS-1:0] thread_busy,
    output logic                   drop_err
);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_FILLING = 2'd1,
        ST_BUSY    = 2'd2
    } thread_state_t;

    localparam logic [SEL_W-1:0]       c_rr_init = SEL_W'(NUM_THREADS - 1);
    localparam logic [NUM_THREADS-1:0] c_one     = NUM_THREADS'(1);

    logic                   r_tgt_valid;
    logic [SEL_W-1:0]       r_cur_thread;
    logic [SEL_W-1:0]       r_rr_ptr;
    logic [NUM_THREADS-1:0] r_enable;
    logic                   r_drop_err;

    logic [NUM_THREADS-1:0] w_free;
    logic [NUM_THREADS-1:0] w_cur_sel;
    logic [NUM_THREADS-1:0] w_win_sel;
    logic [NUM_THREADS-1:0] w_steer;
    logic [SEL_W-1:0]       w_cand;
    logic [SEL_W-1:0]       w_winner;
    logic                   w_found;
    logic                   w_alloc;
    logic                   w_pkt_end;

    assign w_pkt_end = fifowrite_in & lastword_in & r_tgt_valid;
    assign w_alloc   = ~r_tgt_valid & w_found;
    assign w_cur_sel = c_one << r_cur_thread;
    assign w_win_sel = c_one << w_winner;

    // Round-robin search over registered state, starting just after the
    // thread that most recently completed a packet.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            w_cand = SEL_W'((int'(r_rr_ptr) + k) % NUM_THREADS);
            if (!w_found && w_free[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thread
            thread_state_t r_state;
            thread_state_t w_state_nxt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= ST_FREE;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            // A done pulse only matters once the thread holds a full packet.
            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    ST_FREE:    if (w_alloc && w_win_sel[i])   w_state_nxt = ST_FILLING;
                    ST_FILLING: if (w_pkt_end && w_cur_sel[i]) w_state_nxt = ST_BUSY;
                    ST_BUSY:    if (thread_done[i])            w_state_nxt = ST_FREE;
                    default:                                   w_state_nxt = ST_FREE;
                endcase
            end

            assign w_free[i]      = (r_state == ST_FREE);
            assign thread_busy[i] = ~w_free[i];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tgt_valid  <= 1'b0;
            r_cur_thread <= '0;
            r_rr_ptr     <= c_rr_init;
            r_enable     <= '0;
            r_drop_err   <= 1'b0;
        end else begin
            r_enable <= w_pkt_end ? w_cur_sel : '0;
            if (w_pkt_end) begin
                r_tgt_valid <= 1'b0;
                r_rr_ptr    <= r_cur_thread;
            end else if (w_alloc) begin
                r_tgt_valid  <= 1'b1;
                r_cur_thread <= w_winner;
            end
            if (fifowrite_in && !r_tgt_valid) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    assign w_steer             = w_cur_sel & {NUM_THREADS{r_tgt_valid}};
    assign fifowrite_out       = w_steer & {NUM_THREADS{fifowrite_in}};
    assign firstword_out       = w_steer & {NUM_THREADS{firstword_in}};
    assign enable_cpu_out      = r_enable;
    assign stop_smallfifo_read = ~r_tgt_valid;
    assign cur_thread          = r_cur_thread;
    assign tgt_valid           = r_tgt_valid;
    assign drop_err            = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_infifo_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_infifo_dispatcher
//  Brief    : Self-checking bench for infifo_dispatcher.
//  Revision : 1.0  initial release
// ============================================================================
module tb_infifo_dispatcher;
    localparam int N  = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset, firstword_in, lastword_in, fifowrite_in;
    logic [N-1:0]  thread_done;
    logic [N-1:0]  firstword_out, fifowrite_out, enable_cpu_out, thread_busy;
    logic          stop_smallfifo_read, tgt_valid, drop_err;
    logic [SW-1:0] cur_thread;

    infifo_dispatcher #(.NUM_THREADS(N), .SEL_W(SW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .firstword_in        (firstword_in),
        .lastword_in         (lastword_in),
        .fifowrite_in        (fifowrite_in),
        .thread_done         (thread_done),
        .firstword_out       (firstword_out),
        .fifowrite_out       (fifowrite_out),
        .enable_cpu_out      (enable_cpu_out),
        .stop_smallfifo_read (stop_smallfifo_read),
        .cur_thread          (cur_thread),
        .tgt_valid           (tgt_valid),
        .thread_busy         (thread_busy),
        .drop_err            (drop_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = free, 1 = filling, 2 = busy
    int           m_st [N];
    bit           m_tgt;
    int           m_cur;
    int           m_rr;
    logic [N-1:0] m_en;
    bit           m_drop;

    typedef struct {
        bit         fw, lw, wr;
        logic [7:0] dn, fwo, fwdo, en, busy;
        bit         tgt;
        logic [2:0] cur;
    } vec_t;
    vec_t tbl [15];

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] one;
        one = N'(1);
        return one << i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int           old_st [N];
        logic [N-1:0] en_n;
        bit           found;
        if (reset) begin
            for (int i = 0; i < N; i++) m_st[i] = 0;
            m_tgt = 0; m_cur = 0; m_rr = N - 1; m_en = '0; m_drop = 0;
            return;
        end
        old_st = m_st;
        en_n   = '0;
        if (m_tgt) begin
            if (fifowrite_in && lastword_in) begin
                m_st[m_cur] = 2; m_tgt = 0; m_rr = m_cur; en_n = onehot(m_cur);
            end
        end else begin
            if (fifowrite_in) m_drop = 1;
            found = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && old_st[(m_rr + k) % N] == 0) begin
                    found = 1; m_cur = (m_rr + k) % N; m_st[m_cur] = 1; m_tgt = 1;
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (thread_done[i] && old_st[i] == 2) m_st[i] = 0;
        m_en = en_n;
    endtask

    task automatic check_model();
        logic [N-1:0] eb;
        eb = '0;
        for (int i = 0; i < N; i++) eb[i] = (m_st[i] != 0);
        chk("m_fifowrite_out", fifowrite_out, (fifowrite_in && m_tgt) ? onehot(m_cur) : '0);
        chk("m_firstword_out", firstword_out, (firstword_in && m_tgt) ? onehot(m_cur) : '0);
        chk("m_enable_cpu_out", enable_cpu_out, m_en);
        chk("m_thread_busy", thread_busy, eb);
        chk("m_tgt_valid", tgt_valid, m_tgt);
        chk("m_stop", stop_smallfifo_read, !m_tgt);
        chk("m_drop_err", drop_err, m_drop);
        if (m_tgt) chk("m_cur_thread", cur_thread, m_cur);
    endtask

    task automatic drive(input bit rst, fw, lw, wr, input logic [N-1:0] dn);
        reset = rst; firstword_in = fw; lastword_in = lw; fifowrite_in = wr; thread_done = dn;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step(input bit rst, fw, lw, wr, input logic [N-1:0] dn);
        drive(rst, fw, lw, wr, dn);
        check_model();
        tick();
    endtask

    initial begin
        //             fw    lw    wr    dn     fwo    fwdo   en     busy   tgt   cur
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1, 3'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1, 3'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1, 3'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1, 3'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 1'b0, 3'd0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h02, 8'h02, 8'h00, 8'h03, 1'b1, 3'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03, 1'b0, 3'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h07, 1'b1, 3'd2};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 8'h06, 1'b1, 3'd2};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h04, 8'h04, 8'h00, 8'h06, 1'b1, 3'd2};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h04, 8'h06, 1'b0, 3'd0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h08, 8'h08, 8'h00, 8'h0E, 1'b1, 3'd3};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h08, 8'h0E, 1'b0, 3'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1E, 1'b1, 3'd4};

        reset = 1'b1; firstword_in = 1'b0; lastword_in = 1'b0; fifowrite_in = 1'b0; thread_done = '0;
        tick();
        chk("reset_tgt_valid", tgt_valid, 0);
        chk("reset_stop", stop_smallfifo_read, 1);
        chk("reset_busy", thread_busy, 0);
        chk("reset_drop_err", drop_err, 0);

        for (int r = 0; r < 15; r++) begin
            drive(1'b0, tbl[r].fw, tbl[r].lw, tbl[r].wr, tbl[r].dn);
            chk("tbl_fifowrite_out", fifowrite_out, tbl[r].fwo);
            chk("tbl_firstword_out", firstword_out, tbl[r].fwdo);
            chk("tbl_enable_cpu_out", enable_cpu_out, tbl[r].en);
            chk("tbl_thread_busy", thread_busy, tbl[r].busy);
            chk("tbl_tgt_valid", tgt_valid, tbl[r].tgt);
            chk("tbl_stop", stop_smallfifo_read, !tbl[r].tgt);
            if (tbl[r].tgt) chk("tbl_cur_thread", cur_thread, tbl[r].cur);
            check_model();
            tick();
        end

        // Eight back-to-back 2-word packets fill every thread.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int p = 0; p < 8; p++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
            chk("seq_grant", cur_thread, p);
            chk("seq_grant_valid", tgt_valid, 1);
            step(1'b0, 1'b1, 1'b0, 1'b1, '0);
            step(1'b0, 1'b0, 1'b1, 1'b1, '0);
            chk("seq_enable", enable_cpu_out, onehot(p));
            chk("seq_stop_gap", stop_smallfifo_read, 1);
        end
        chk("seq_all_busy", thread_busy, 8'hFF);
        chk("seq_all_busy_tgt", tgt_valid, 0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
            chk("seq_stop_held", stop_smallfifo_read, 1);
        end

        // Word with no target is dropped.
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
        check_model();
        chk("drop_no_write", fifowrite_out, 0);
        tick();
        chk("drop_err_set", drop_err, 1);

        // Done on thread 5 frees it, grant follows one edge later.
        step(1'b0, 1'b0, 1'b0, 1'b0, onehot(5));
        chk("done5_busy", thread_busy, 8'hDF);
        chk("done5_tgt", tgt_valid, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("done5_tgt_valid", tgt_valid, 1);
        chk("done5_cur", cur_thread, 5);
        chk("done5_stop", stop_smallfifo_read, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, '0);

        // rr_ptr=2 with threads 1 and 6 free must pick 6.
        step(1'b0, 1'b0, 1'b0, 1'b0, onehot(2));
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("rr_cur2", cur_thread, 2);
        step(1'b0, 1'b0, 1'b0, 1'b0, onehot(1) | onehot(6));
        chk("rr_busy", thread_busy, 8'hBD);
        step(1'b0, 1'b1, 1'b1, 1'b1, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("rr_grant6", cur_thread, 6);
        chk("rr_grant_valid", tgt_valid, 1);
        chk("drop_err_sticky", drop_err, 1);

        // Reset mid-packet, coinciding with a packet end.
        step(1'b0, 1'b1, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b1, 1'b1, '0);
        chk("rst_busy", thread_busy, 0);
        chk("rst_tgt", tgt_valid, 0);
        chk("rst_enable", enable_cpu_out, 0);
        chk("rst_drop", drop_err, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_regrant_valid", tgt_valid, 1);
        chk("rst_regrant_cur", cur_thread, 0);

        // Randomised traffic against the model.
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0,
                 N'($urandom & $urandom & $urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
